// File: rtl/timer_arbiter.sv
// Round-robin arbiter handing a single prescaled tick timer to one of NUM_REQ requesters.
// The owner holds the timer for its captured duration, gets a one-cycle done pulse, then releases it.
module timer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int COUNT_WIDTH    = 8,
  parameter int PRESCALE       = 1000,
  parameter int PRESCALE_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] dur,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic [NUM_REQ-1:0]             done,
  output logic [COUNT_WIDTH-1:0]         count
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);
  localparam logic [PRESCALE_WIDTH-1:0] PRE_MAX = PRESCALE_WIDTH'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             owner_q, owner_d, last_q, last_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d, done_q, done_d;
  logic [COUNT_WIDTH-1:0]    dur_q, dur_d, count_q, count_d, count_inc;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      win_vld, tick;
  logic [IW-1:0]             win_idx;

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin : rr_pick
    logic [IW:0] sum;
    sum     = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_q} + (IW+1)'(k);
      if (sum >= NREQ) sum = sum - NREQ;
      if (!win_vld && req[sum[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = sum[IW-1:0];
      end
    end
  end

  assign tick      = (state_q == RUN) && (pre_q == PRE_MAX);
  assign count_inc = count_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    dur_d   = dur_q;
    count_d = count_q;
    pre_d   = pre_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        count_d = '0;
        pre_d   = '0;
        if (win_vld) begin
          state_d = RUN;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          for (int i = 0; i < NUM_REQ; i++)
            if (win_idx == IW'(i)) dur_d = dur[i*COUNT_WIDTH +: COUNT_WIDTH];
        end
      end
      RUN: begin
        if (!req[owner_q]) begin
          // Abandoned by the owner: release silently, still advance the rotation.
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          pre_d   = '0;
          last_d  = owner_q;
        end else if (dur_q == '0) begin
          state_d = DONE;
          done_d  = grant_q;
        end else begin
          pre_d = tick ? '0 : pre_q + PRESCALE_WIDTH'(1);
          if (tick) begin
            count_d = count_inc;
            if (count_inc == dur_q) begin
              state_d = DONE;
              done_d  = grant_q;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        count_d = '0;
        pre_d   = '0;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      dur_q   <= '0;
      count_q <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      dur_q   <= dur_d;
      count_q <= count_d;
      pre_q   <= pre_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign count = count_q;
  assign busy  = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_timer_arbiter.sv
// Scenario bench for timer_arbiter: expected done events queued at stimulus time, popped when done fires.
module tb_timer_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] dur = '0;
  logic [3:0]  grant, done;
  logic        busy;
  logic [7:0]  count;

  typedef struct {
    logic [3:0] done;
    logic [7:0] count;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t ex;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  timer_arbiter #(.NUM_REQ(4), .COUNT_WIDTH(8), .PRESCALE(4), .PRESCALE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .req(req), .dur(dur),
    .grant(grant), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; dur = '0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b1111; dur = '0;
    @(negedge clk);
    checks++; if (grant !== 4'b0) $display("FAIL reset_grant got=%b want=0000", grant); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passes++;
    checks++; if (done !== 4'b0) $display("FAIL reset_done got=%b want=0000", done); else passes++;
    checks++; if (count !== 8'd0) $display("FAIL reset_count got=%0d want=0", count); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 4'b0) $display("FAIL reset_hold_grant got=%b want=0000", grant); else passes++;
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    int base; logic [3:0] eg; logic [7:0] ec;
    do_reset();
    dur[7:0] = 8'd3; req = 4'b0001; base = cyc;
    sb.push_back('{done: 4'b0001, count: 8'd3, at: base + 13});
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      eg = (e <= 13) ? 4'b0001 : 4'b0000;
      ec = (e <= 13) ? 8'((e - 1) / 4) : 8'd0;
      checks++;
      if (grant !== eg || count !== ec || busy !== (e <= 13))
        $display("FAIL single_e%0d grant=%b count=%0d busy=%b want grant=%b count=%0d", e, grant, count, busy, eg, ec);
      else passes++;
      if (done !== 4'b0) begin
        checks++;
        if (sb.size() == 0) $display("FAIL single_spurious done=%b cyc=%0d", done, cyc);
        else begin
          ex = sb.pop_front();
          if (done !== ex.done || count !== ex.count || cyc != ex.at)
            $display("FAIL single_done got done=%b count=%0d cyc=%0d want done=%b count=%0d cyc=%0d", done, count, cyc, ex.done, ex.count, ex.at);
          else passes++;
        end
      end
    end
    req = '0;
    checks++; if (sb.size() != 0) $display("FAIL single_missing_done pending=%0d want=0", sb.size()); else passes++;
  endtask

  task automatic test_round_robin();
    int base; logic [3:0] eg;
    do_reset();
    dur = 32'h01010101; req = 4'b0101; base = cyc;
    for (int k = 0; k < 4; k++)
      sb.push_back('{done: (k % 2 == 0) ? 4'b0001 : 4'b0100, count: 8'd1, at: base + 6 * k + 5});
    for (int e = 1; e <= 24; e++) begin
      @(negedge clk);
      if ((e - 1) % 6 <= 4) eg = (((e - 1) / 6) % 2 == 0) ? 4'b0001 : 4'b0100;
      else eg = 4'b0000;
      checks++;
      if (grant !== eg) $display("FAIL rr_e%0d grant=%b want=%b", e, grant, eg); else passes++;
      if (done !== 4'b0) begin
        checks++;
        if (sb.size() == 0) $display("FAIL rr_spurious done=%b cyc=%0d", done, cyc);
        else begin
          ex = sb.pop_front();
          if (done !== ex.done || count !== ex.count || cyc != ex.at)
            $display("FAIL rr_done got done=%b count=%0d cyc=%0d want done=%b count=%0d cyc=%0d", done, count, cyc, ex.done, ex.count, ex.at);
          else passes++;
        end
      end
    end
    req = '0;
    checks++; if (sb.size() != 0) $display("FAIL rr_missing_done pending=%0d want=0", sb.size()); else passes++;
  endtask

  task automatic test_zero_dur();
    int base;
    do_reset();
    dur[15:8] = 8'd0; req = 4'b0010; base = cyc;
    sb.push_back('{done: 4'b0010, count: 8'd0, at: base + 2});
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if (grant !== ((e <= 2) ? 4'b0010 : 4'b0000) || count !== 8'd0)
        $display("FAIL zero_e%0d grant=%b count=%0d want grant=%b count=0", e, grant, count, (e <= 2) ? 4'b0010 : 4'b0000);
      else passes++;
      if (done !== 4'b0) begin
        checks++;
        if (sb.size() == 0) $display("FAIL zero_spurious done=%b cyc=%0d", done, cyc);
        else begin
          ex = sb.pop_front();
          if (done !== ex.done || count !== ex.count || cyc != ex.at)
            $display("FAIL zero_done got done=%b count=%0d cyc=%0d want done=%b count=%0d cyc=%0d", done, count, cyc, ex.done, ex.count, ex.at);
          else passes++;
        end
      end
    end
    req = '0;
    checks++; if (sb.size() != 0) $display("FAIL zero_missing_done pending=%0d want=0", sb.size()); else passes++;
  endtask

  // Owner drops out mid-run; live dur and a non-owner request change meanwhile.
  task automatic test_abort();
    logic [3:0] eg; logic [7:0] ec;
    do_reset();
    dur[31:24] = 8'd10; req = 4'b1000;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      eg = (e <= 6) ? 4'b1000 : (e == 7) ? 4'b0000 : 4'b0001;
      ec = (e <= 6) ? 8'((e - 1) / 4) : 8'd0;
      checks++;
      if (grant !== eg || count !== ec || busy !== (e != 7))
        $display("FAIL abort_e%0d grant=%b count=%0d busy=%b want grant=%b count=%0d", e, grant, count, busy, eg, ec);
      else passes++;
      if (done !== 4'b0) begin
        checks++;
        $display("FAIL abort_spurious done=%b cyc=%0d want=0000", done, cyc);
      end
      if (e == 2) dur[31:24] = 8'd1;
      if (e == 3) req = 4'b1001;
      if (e == 6) req = 4'b0001;
      if (e == 7) req = 4'b1001;
    end
    req = '0;
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] eg; logic [7:0] ec;
    do_reset();
    dur[7:0] = 8'd5; req = 4'b0001;
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      eg = (e <= 9 || (e >= 11 && e <= 14)) ? 4'b0001 : 4'b0000;
      ec = (e <= 9) ? 8'((e - 1) / 4) : 8'd0;
      checks++;
      if (grant !== eg || count !== ec || done !== 4'b0 || busy !== (eg != 4'b0))
        $display("FAIL rstrun_e%0d grant=%b count=%0d done=%b busy=%b want grant=%b count=%0d done=0000", e, grant, count, done, busy, eg, ec);
      else passes++;
      if (e == 9) rst = 1'b1;
      if (e == 10) begin rst = 1'b0; dur[7:0] = 8'd1; end
      if (e == 14) rst = 1'b1;
    end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_max_dur();
    int base; logic [3:0] eg; logic [7:0] ec;
    do_reset();
    dur[31:24] = 8'd255; req = 4'b1000; base = cyc;
    sb.push_back('{done: 4'b1000, count: 8'd255, at: base + 1021});
    for (int e = 1; e <= 1022; e++) begin
      @(negedge clk);
      eg = (e <= 1021) ? 4'b1000 : 4'b0000;
      ec = (e <= 1021) ? 8'((e - 1) / 4) : 8'd0;
      checks++;
      if (grant !== eg || count !== ec)
        $display("FAIL maxdur_e%0d grant=%b count=%0d want grant=%b count=%0d", e, grant, count, eg, ec);
      else passes++;
      if (done !== 4'b0) begin
        checks++;
        if (sb.size() == 0) $display("FAIL maxdur_spurious done=%b cyc=%0d", done, cyc);
        else begin
          ex = sb.pop_front();
          if (done !== ex.done || count !== ex.count || cyc != ex.at)
            $display("FAIL maxdur_done got done=%b count=%0d cyc=%0d want done=%b count=%0d cyc=%0d", done, count, cyc, ex.done, ex.count, ex.at);
          else passes++;
        end
      end
    end
    req = '0;
    checks++; if (sb.size() != 0) $display("FAIL maxdur_missing_done pending=%0d want=0", sb.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_dur();
    test_abort();
    test_reset_mid_run();
    test_max_dur();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the timer (>=2).
REQ-002 Parameter COUNT_WIDTH, default 8, width of duration and tick counter.
REQ-003 Parameter PRESCALE, default 1000, clk cycles per timer tick (>=1).
REQ-004 Parameter PRESCALE_WIDTH, default 10, prescaler width (2^PRESCALE_WIDTH >= PRESCALE).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req  input  NUM_REQ  per-requester level request, held until done or abandon.
REQ-008 dur  input  NUM_REQ*COUNT_WIDTH  per-requester duration in ticks, slice i = requester i.
REQ-009 grant  output  NUM_REQ  one-hot (or zero) owner of the timer.
REQ-010 busy  output  1  high in RUN or DONE.
REQ-011 done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-012 count  output  COUNT_WIDTH  ticks elapsed for current owner.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; only these are reachable.
REQ-014 IDLE, any req high: next edge SHALL enter RUN, set grant to winner, capture winner dur, clear count and prescaler.
REQ-015 Winner SHALL be the first requester with req high scanning from (last_owner+1) mod NUM_REQ upward with wrap (round robin).
REQ-016 IDLE, no req: SHALL stay IDLE, grant=0, count=0.
REQ-017 RUN: prescaler SHALL increment each cycle; at PRESCALE-1 it SHALL wrap to 0 and produce a tick that same cycle.
REQ-018 Tick in RUN: count SHALL increment by 1; if new count equals captured dur, SHALL enter DONE on that edge.
REQ-019 Captured dur of 0: RUN SHALL enter DONE on the first edge after grant, count stays 0.
REQ-020 Latency: grant asserted at edge N, dur D>=1 -> DONE entered at edge N+D*PRESCALE.
REQ-021 DONE: done[owner] SHALL be high exactly one cycle, grant and count held; next edge SHALL enter IDLE, clear grant, record owner as last_owner.
REQ-022 In DONE and on return to IDLE, a new grant SHALL NOT issue before the first IDLE cycle (one idle cycle between owners).
REQ-023 Owner req low during RUN: SHALL abort to IDLE on next edge, no done pulse, last_owner updated.
REQ-024 Owner req low during DONE: done pulse SHALL still complete; no effect.
REQ-025 Changes to dur or non-owner req during RUN SHALL be ignored.
REQ-026 count SHALL never wrap; max dur 2^COUNT_WIDTH-1 completes normally.
REQ-027 grant SHALL never have more than one bit set; done SHALL only pulse on the granted bit.

Reset
REQ-028 rst high SHALL on next edge force IDLE, grant=0, done=0, busy=0, count=0, prescaler=0, last_owner=NUM_REQ-1 (requester 0 first priority).
REQ-029 rst SHALL override all other inputs, including mid-RUN and during DONE (no done pulse emitted).

Verification (NUM_REQ=4, COUNT_WIDTH=8, PRESCALE=4)
REQ-030 After reset, req=0001, dur0=3 -> grant=0001 at edge 1, count 1/2/3 at edges 5/9/13, done[0] high edge 13 only, grant=0 edge 14.
REQ-031 After reset, req=0101 held, all dur=1 -> grants 0001, 0100, 0001, 0100 in order, one IDLE cycle between each.
REQ-032 req=0010, dur1=0 -> grant=0010 edge 1, done[1] edge 2, count=0 throughout.
REQ-033 req=1000, dur3=10, drop req3 at cycle 6 -> IDLE next edge, no done, next req=1001 grants requester 0.
REQ-034 rst pulsed mid-RUN with count=2 -> next edge all outputs zero, no done, then req=0001 grants requester 0.
REQ-035 dur3=255, req=1000 -> done[3] at edge 1+1020, count=255, no wrap.
